// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master sequencer.
package axil_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERR  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_RESP,
      S_DONE
   } axil_seq_state_e;

endpackage

// File: rtl/axil_master_seq_if.sv
// Command/response port plus AXI4-Lite bus signals of the sequencer.
interface axil_master_seq_if;
   import axil_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_wstrb;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              AWVALID;
   logic              AWREADY;
   logic [ADDR_W-1:0] AWADDR;
   logic              AWPROT;
   logic              WVALID;
   logic              WREADY;
   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              BVALID;
   logic              BREADY;
   logic              BRESP;
   logic              ARVALID;
   logic              ARREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic              ARPROT;
   logic              RVALID;
   logic              RREADY;
   logic [DATA_W-1:0] RDATA;
   logic              RRESP;

   // Sequencer side: consumes commands, drives the AXI master channels.
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output AWVALID, AWADDR, AWPROT, input AWREADY,
      output WVALID, WDATA, WSTRB, input WREADY,
      input  BVALID, BRESP, output BREADY,
      output ARVALID, ARADDR, ARPROT, input ARREADY,
      input  RVALID, RDATA, RRESP, output RREADY
   );

   // Requester plus AXI slave side.
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  AWVALID, AWADDR, AWPROT, output AWREADY,
      input  WVALID, WDATA, WSTRB, output WREADY,
      output BVALID, BRESP, input BREADY,
      input  ARVALID, ARADDR, ARPROT, output ARREADY,
      output RVALID, RDATA, RRESP, input RREADY
   );

endinterface

// File: rtl/axil_master_seq.sv
// Single-outstanding AXI4-Lite master: one command in, one full write or read
// transaction out, with a timeout so a hung slave cannot stall the requester.
module axil_master_seq
   import axil_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic        PROT_VAL       = 1'b0
) (
   input logic               ACLK,
   input logic               ARESETN,
   axil_master_seq_if.master bus
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   axil_seq_state_e   state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              aw_done, w_done;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q, tmo_q;
   logic              accept, expired, b_hs, r_hs, abort;

   assign expired = (cnt == CNT_LAST);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Expiry outranks request-phase handshakes; only the B/R handshake beats it.
   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      abort         = 1'b0;
      b_hs          = 1'b0;
      r_hs          = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.AWVALID   = 1'b0;
      bus.WVALID    = 1'b0;
      bus.BREADY    = 1'b0;
      bus.ARVALID   = 1'b0;
      bus.RREADY    = 1'b0;
      unique case (state)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               accept    = 1'b1;
               state_nxt = bus.cmd_write ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            bus.AWVALID = !aw_done;
            bus.WVALID  = !w_done;
            if (expired) begin
               abort     = 1'b1;
               state_nxt = S_DONE;
            end else if ((aw_done || bus.AWREADY) && (w_done || bus.WREADY)) begin
               state_nxt = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            bus.BREADY = 1'b1;
            if (bus.BVALID) begin
               b_hs      = 1'b1;
               state_nxt = S_DONE;
            end else if (expired) begin
               abort     = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_RD_REQ: begin
            bus.ARVALID = 1'b1;
            if (expired) begin
               abort     = 1'b1;
               state_nxt = S_DONE;
            end else if (bus.ARREADY) begin
               state_nxt = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            bus.RREADY = 1'b1;
            if (bus.RVALID) begin
               r_hs      = 1'b1;
               state_nxt = S_DONE;
            end else if (expired) begin
               abort     = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            bus.rsp_valid = 1'b1;
            state_nxt     = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cnt     <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= RESP_OKAY;
         tmo_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            wstrb_q <= bus.cmd_wstrb;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else if (state inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP}) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (state == S_WR_REQ) begin
            if (bus.AWREADY) aw_done <= 1'b1;
            if (bus.WREADY)  w_done  <= 1'b1;
         end

         if (abort) begin
            tmo_q   <= 1'b1;
            err_q   <= RESP_ERR;
            rdata_q <= '0;
         end else if (b_hs) begin
            tmo_q   <= 1'b0;
            err_q   <= bus.BRESP;
            rdata_q <= '0;
         end else if (r_hs) begin
            tmo_q   <= 1'b0;
            err_q   <= bus.RRESP;
            rdata_q <= bus.RDATA;
         end
      end
   end

   assign bus.AWADDR      = addr_q;
   assign bus.AWPROT      = PROT_VAL;
   assign bus.WDATA       = wdata_q;
   assign bus.WSTRB       = wstrb_q;
   assign bus.ARADDR      = addr_q;
   assign bus.ARPROT      = PROT_VAL;
   assign bus.rsp_rdata   = rdata_q;
   assign bus.rsp_err     = err_q;
   assign bus.rsp_timeout = tmo_q;

endmodule

// File: tb/tb_axil_master_seq.sv
// Randomized bench for axil_master_seq: delay-programmable slave, timeline
// model of each transaction, per-cycle payload and handshake-count checks.
module tb_axil_master_seq;
   import axil_pkg::*;

   localparam int unsigned T = 8;
   localparam int          NEVER = 1000;

   logic ACLK    = 1'b0;
   logic ARESETN = 1'b0;

   axil_master_seq_if bus ();

   axil_master_seq #(.TIMEOUT_CYCLES(T), .PROT_VAL(1'b0)) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Slave behaviour for the current transaction.
   int          d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
   logic        bresp_v = 1'b0, rresp_v = 1'b0;
   logic [31:0] rdata_v = '0;
   int          aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;

   always @(posedge ACLK) begin
      aw_c <= (bus.AWVALID && !bus.AWREADY) ? aw_c + 1 : 0;
      w_c  <= (bus.WVALID  && !bus.WREADY)  ? w_c  + 1 : 0;
      b_c  <= (bus.BREADY  && !bus.BVALID)  ? b_c  + 1 : 0;
      ar_c <= (bus.ARVALID && !bus.ARREADY) ? ar_c + 1 : 0;
      r_c  <= (bus.RREADY  && !bus.RVALID)  ? r_c  + 1 : 0;
   end

   assign bus.AWREADY = bus.AWVALID && (aw_c >= d_aw);
   assign bus.WREADY  = bus.WVALID  && (w_c  >= d_w);
   assign bus.BVALID  = bus.BREADY  && (b_c  >= d_b);
   assign bus.ARREADY = bus.ARVALID && (ar_c >= d_ar);
   assign bus.RVALID  = bus.RREADY  && (r_c  >= d_r);
   assign bus.BRESP   = bresp_v;
   assign bus.RRESP   = rresp_v;
   assign bus.RDATA   = rdata_v;

   // Current command and bookkeeping
   logic        exp_wr;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_strb;
   int          t0 = 0;
   int          last_rsp = 0;
   bit          hold_prev = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int pick_d();
      return ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 4));
   endfunction

   task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                            input logic br, input logic rr, input logic [31:0] rd);
      d_aw = aw; d_w = w; d_b = b; d_ar = ar; d_r = r;
      bresp_v = br; rresp_v = rr; rdata_v = rd;
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
      check({pfx, "_awvalid"},   bus.AWVALID, 0);
      check({pfx, "_wvalid"},    bus.WVALID, 0);
      check({pfx, "_bready"},    bus.BREADY, 0);
      check({pfx, "_arvalid"},   bus.ARVALID, 0);
      check({pfx, "_rready"},    bus.RREADY, 0);
      check({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
      check({pfx, "_rsp_rdata"}, bus.rsp_rdata, 0);
      check({pfx, "_rsp_err"},   bus.rsp_err, 0);
      check({pfx, "_rsp_tmo"},   bus.rsp_timeout, 0);
      check({pfx, "_awaddr"},    bus.AWADDR, 0);
      check({pfx, "_wdata"},     bus.WDATA, 0);
   endtask

   // Present a command and return at the falling edge one cycle after accept.
   task automatic start_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit hold);
      int n;
      exp_wr = wr; exp_addr = a; exp_wdata = d; exp_strb = s;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.cmd_wstrb = s;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      check("accept_ready", bus.cmd_ready, 1);
      t0 = cyc;
      if (hold_prev) check("b2b_accept_cycle", t0, last_rsp + 1);
      hold_prev = hold;
      @(negedge ACLK);
      if (!hold) bus.cmd_valid = 1'b0;
   endtask

   // Timeline model: cycle k counts from 0 at the first cycle after accept;
   // the B/R handshake lands at k = 1 + request-phase delay + response delay.
   task automatic finish_cmd();
      int tt, req, kh, e_cyc, e_aw, e_w, e_ar, e_b, e_r, e_first;
      logic e_tmo, e_err;
      logic [31:0] e_rdata;
      int n_aw, n_w, n_ar, n_b, n_r, first;
      bit got;

      tt  = int'(T);
      req = exp_wr ? imax(d_aw, d_w) : d_ar;
      kh  = 1 + req + (exp_wr ? d_b : d_r);
      if (kh <= tt - 1) begin
         e_tmo   = 1'b0;
         e_cyc   = t0 + kh + 2;
         e_err   = exp_wr ? bresp_v : rresp_v;
         e_rdata = exp_wr ? 32'h0 : rdata_v;
      end else begin
         e_tmo   = 1'b1;
         e_cyc   = t0 + tt + 1;
         e_err   = 1'b1;
         e_rdata = 32'h0;
      end
      e_aw = exp_wr ? imin(d_aw + 1, tt) : 0;
      e_w  = exp_wr ? imin(d_w + 1, tt)  : 0;
      e_ar = exp_wr ? 0 : imin(d_ar + 1, tt);
      if (req <= tt - 2) begin
         e_first = t0 + 2 + req;
         e_b     = exp_wr ? imin(kh, tt - 1) - (1 + req) + 1 : 0;
         e_r     = exp_wr ? 0 : imin(kh, tt - 1) - (1 + req) + 1;
      end else begin
         e_first = -1;
         e_b     = 0;
         e_r     = 0;
      end

      n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; first = -1; got = 1'b0;
      for (int i = 0; i < int'(T) + 20; i++) begin
         if (bus.rsp_valid) begin
            got = 1'b1;
            break;
         end
         if (bus.AWVALID) begin
            n_aw++;
            check("awaddr", bus.AWADDR, exp_addr);
            check("awprot", bus.AWPROT, 0);
         end
         if (bus.WVALID) begin
            n_w++;
            check("wdata", bus.WDATA, exp_wdata);
            check("wstrb", bus.WSTRB, exp_strb);
         end
         if (bus.ARVALID) begin
            n_ar++;
            check("araddr", bus.ARADDR, exp_addr);
            check("arprot", bus.ARPROT, 0);
         end
         if (bus.BREADY) begin
            n_b++;
            if (first < 0) first = cyc;
         end
         if (bus.RREADY) begin
            n_r++;
            if (first < 0) first = cyc;
         end
         @(negedge ACLK);
      end
      check("rsp_seen", got, 1);
      check("rsp_cycle", cyc, e_cyc);
      check("rsp_rdata", bus.rsp_rdata, e_rdata);
      check("rsp_err", bus.rsp_err, e_err);
      check("rsp_timeout", bus.rsp_timeout, e_tmo);
      check("awvalid_cycles", n_aw, e_aw);
      check("wvalid_cycles", n_w, e_w);
      check("arvalid_cycles", n_ar, e_ar);
      check("bready_cycles", n_b, e_b);
      check("rready_cycles", n_r, e_r);
      check("resp_phase_start", first, e_first);
      last_rsp = cyc;
      @(negedge ACLK);
      check("rsp_one_cycle", bus.rsp_valid, 0);
      check("idle_ready", bus.cmd_ready, 1);
      check("rsp_hold", bus.rsp_rdata, e_rdata);
   endtask

   initial begin
      int          n;
      logic        wr;
      logic [31:0] a, d;
      logic [3:0]  s;
      bit          hold;

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_wstrb = '0;

      repeat (2) @(negedge ACLK);
      check_reset("por");
      ARESETN = 1'b1;
      @(negedge ACLK);

      // Minimum-latency write
      set_slave(0, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
      start_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
      finish_cmd();

      // Read with delayed ARREADY and RVALID, error response
      set_slave(0, 0, 0, 3, 2, 1'b0, 1'b1, 32'h1234_5678);
      start_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
      finish_cmd();

      // Write with W accepted early and AW late
      set_slave(4, 1, 0, 0, 0, 1'b0, 1'b0, 32'h0);
      start_cmd(1'b1, 32'h0000_0030, 32'hCAFE_0001, 4'h5, 1'b0);
      finish_cmd();

      // Read against a slave that never accepts the address
      set_slave(0, 0, 0, NEVER, 0, 1'b0, 1'b0, 32'hFFFF_FFFF);
      start_cmd(1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b0);
      finish_cmd();

      // Reset asserted while waiting for the write response
      set_slave(0, 0, NEVER, 0, 0, 1'b0, 1'b0, 32'h0);
      start_cmd(1'b1, 32'h0000_0040, 32'hA5A5_0001, 4'h3, 1'b0);
      n = 0;
      while (!bus.BREADY && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      check("reach_wr_resp", bus.BREADY, 1);
      #2 ARESETN = 1'b0;
      #1 check_reset("mid_rst");
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         check("rst_no_rsp", bus.rsp_valid, 0);
      end
      ARESETN = 1'b1;
      @(negedge ACLK);
      set_slave(1, 0, 0, 1, 1, 1'b0, 1'b0, 32'h0BAD_F00D);
      start_cmd(1'b0, 32'h0000_0050, 32'h0, 4'h0, 1'b0);
      finish_cmd();

      // Back-to-back writes with cmd_valid held high
      set_slave(0, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
      start_cmd(1'b1, 32'h0000_0060, 32'h1111_2222, 4'hC, 1'b1);
      finish_cmd();
      set_slave(0, 0, 0, 0, 0, 1'b1, 1'b0, 32'h0);
      start_cmd(1'b1, 32'h0000_0064, 32'h3333_4444, 4'h3, 1'b0);
      finish_cmd();

      // Randomized traffic, including timeouts in every phase
      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom_range(0, 1));
         a    = $urandom & 32'hFFFF_FFFC;
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         hold = (i != 39) && ($urandom_range(0, 3) == 0);
         set_slave(pick_d(), pick_d(), pick_d(), pick_d(), pick_d(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         start_cmd(wr, a, d, s, hold);
         finish_cmd();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
